// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with flush
// to a bubble pattern, optional 2-entry skid buffer and stall counter.
//
// Ports:
//   CLK, RSTN           clock (rising), async active-low reset
//   FLUSH               sync flush, drops all entries to BUBBLE
//   IN_VALID/IN_READY   upstream handshake, IN_DATA payload
//   OUT_VALID/OUT_READY downstream handshake, OUT_DATA payload
//   OCC                 entry count (0..2)
//   CNT_CLR/STALL_CNT   clear / saturating count of stalled cycles
module pipe_stage_elastic #(
    parameter int unsigned    W       = 32,
    parameter logic [W-1:0]   BUBBLE  = '0,
    parameter bit             SKID_EN = 1'b1,
    parameter int unsigned    CW      = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          FLUSH,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [W-1:0]  OUT_DATA,
    output logic [1:0]    OCC,
    input  logic          CNT_CLR,
    output logic [CW-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        r_state;
    logic [W-1:0]  r_main;
    logic [W-1:0]  r_skid;
    logic          r_valid;
    logic          r_in_ready;
    logic [CW-1:0] r_cnt;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_stall;

    // Without the skid entry, ready must look through to OUT_READY
    // to keep one entry per cycle.
    assign IN_READY   = SKID_EN ? r_in_ready : (~r_valid | OUT_READY);
    assign w_in_fire  = IN_VALID & IN_READY;
    assign w_out_fire = r_valid & OUT_READY;
    assign w_stall    = r_valid & ~OUT_READY;

    assign OUT_VALID  = r_valid;
    assign OUT_DATA   = r_main;
    assign OCC        = r_state;
    assign STALL_CNT  = r_cnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (FLUSH) begin
            r_state    <= S_EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= IN_DATA;
                        r_valid <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= IN_DATA;
                    end else if (w_in_fire && SKID_EN) begin
                        r_skid     <= IN_DATA;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (w_out_fire) begin
                        r_main  <= BUBBLE;
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_skid     <= BUBBLE;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_main     <= BUBBLE;
                    r_skid     <= BUBBLE;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stall counter ignores FLUSH; clear beats increment.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (CNT_CLR) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed bench for pipe_stage_elastic,
// one skid instance and one single-register instance.
module tb_pipe_stage_elastic;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // skid instance (a)
    logic       rstn_a, flush_a, iv_a, ird_a, ov_a, ordy_a, clr_a;
    logic [7:0] id_a, od_a;
    logic [1:0] occ_a;
    logic [3:0] sc_a;

    // single-register instance (b)
    logic       rstn_b, flush_b, iv_b, ird_b, ov_b, ordy_b, clr_b;
    logic [7:0] id_b, od_b;
    logic [1:0] occ_b;
    logic [3:0] sc_b;

    pipe_stage_elastic #(
        .W(8), .BUBBLE(8'hA5), .SKID_EN(1'b1), .CW(4)
    ) u_a (
        .CLK(clk), .RSTN(rstn_a), .FLUSH(flush_a),
        .IN_VALID(iv_a), .IN_READY(ird_a), .IN_DATA(id_a),
        .OUT_VALID(ov_a), .OUT_READY(ordy_a), .OUT_DATA(od_a),
        .OCC(occ_a), .CNT_CLR(clr_a), .STALL_CNT(sc_a)
    );

    pipe_stage_elastic #(
        .W(8), .BUBBLE(8'hA5), .SKID_EN(1'b0), .CW(4)
    ) u_b (
        .CLK(clk), .RSTN(rstn_b), .FLUSH(flush_b),
        .IN_VALID(iv_b), .IN_READY(ird_b), .IN_DATA(id_b),
        .OUT_VALID(ov_b), .OUT_READY(ordy_b), .OUT_DATA(od_b),
        .OCC(occ_b), .CNT_CLR(clr_b), .STALL_CNT(sc_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v,
                         input logic [7:0] d, input logic [1:0] o,
                         input logic r);
        chk({tag, ".ov"},  {31'd0, ov_a},  {31'd0, v});
        chk({tag, ".od"},  {24'd0, od_a},  {24'd0, d});
        chk({tag, ".occ"}, {30'd0, occ_a}, {30'd0, o});
        chk({tag, ".ird"}, {31'd0, ird_a}, {31'd0, r});
    endtask

    initial begin
        rstn_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; id_a = 8'h00;
        ordy_a = 1'b0; clr_a = 1'b0;
        rstn_b = 1'b1; flush_b = 1'b0; iv_b = 1'b0; id_b = 8'h00;
        ordy_b = 1'b0; clr_b = 1'b0;
        #1;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        #1;
        chk_a("rst", 1'b0, 8'hA5, 2'd0, 1'b1);
        chk("rst.sc", {28'd0, sc_a}, 32'd0);
        step();
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // idle
        for (int i = 0; i < 10; i++) begin
            step();
            chk_a("idle", 1'b0, 8'hA5, 2'd0, 1'b1);
        end

        // streaming 01..10
        ordy_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            iv_a = 1'b1;
            id_a = 8'(i);
            step();
            chk_a("strm", 1'b1, 8'(i), 2'd1, 1'b1);
            chk("strm.sc", {28'd0, sc_a}, 32'd0);
        end
        iv_a = 1'b0;
        step();
        chk_a("drain", 1'b0, 8'hA5, 2'd0, 1'b1);

        // backpressure into skid
        ordy_a = 1'b0;
        iv_a = 1'b1; id_a = 8'h11;
        step();
        chk_a("bp1", 1'b1, 8'h11, 2'd1, 1'b1);
        id_a = 8'h22;
        step();
        chk_a("bp2", 1'b1, 8'h11, 2'd2, 1'b0);
        id_a = 8'h33;
        step();
        chk_a("bp3", 1'b1, 8'h11, 2'd2, 1'b0);
        step();
        chk_a("bp4", 1'b1, 8'h11, 2'd2, 1'b0);
        chk("bp.sc", {28'd0, sc_a}, 32'd3);
        ordy_a = 1'b1;
        step();
        chk_a("bp5", 1'b1, 8'h22, 2'd1, 1'b1);
        step();
        chk_a("bp6", 1'b1, 8'h33, 2'd1, 1'b1);
        iv_a = 1'b0;
        step();
        chk_a("bp7", 1'b0, 8'hA5, 2'd0, 1'b1);
        chk("bp7.sc", {28'd0, sc_a}, 32'd3);

        // flush from FULL with upstream pending
        ordy_a = 1'b0;
        iv_a = 1'b1; id_a = 8'h44;
        step();
        id_a = 8'h55;
        step();
        chk_a("fl.full", 1'b1, 8'h44, 2'd2, 1'b0);
        id_a = 8'h66;
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        iv_a = 1'b0;
        chk_a("fl1", 1'b0, 8'hA5, 2'd0, 1'b1);
        chk("fl1.sc", {28'd0, sc_a}, 32'd5);
        // in_fire during flush from EMPTY is dropped
        iv_a = 1'b1; id_a = 8'h66; flush_a = 1'b1;
        step();
        chk_a("fl2", 1'b0, 8'hA5, 2'd0, 1'b1);
        flush_a = 1'b0; iv_a = 1'b0;
        step();
        chk_a("fl3", 1'b0, 8'hA5, 2'd0, 1'b1);

        // saturation
        clr_a = 1'b1;
        iv_a = 1'b1; id_a = 8'h77;
        step();
        clr_a = 1'b0; iv_a = 1'b0;
        chk("sat0", {28'd0, sc_a}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("sat", {28'd0, sc_a}, (k > 15) ? 32'd15 : 32'(k));
        end
        chk("sat.od", {24'd0, od_a}, 32'h77);
        clr_a = 1'b1;
        step();
        chk("clr", {28'd0, sc_a}, 32'd0);
        clr_a = 1'b0;
        step();
        chk("clr.inc", {28'd0, sc_a}, 32'd1);
        ordy_a = 1'b1;
        step();
        chk_a("sat.drain", 1'b0, 8'hA5, 2'd0, 1'b1);
        chk("sat.sc", {28'd0, sc_a}, 32'd1);

        // single-register instance
        ordy_b = 1'b1;
        iv_b = 1'b1; id_b = 8'h90;
        step();
        chk("b.s0", {24'd0, od_b}, 32'h90);
        id_b = 8'h91;
        step();
        chk("b.s1", {24'd0, od_b}, 32'h91);
        chk("b.s1.occ", {30'd0, occ_b}, 32'd1);
        iv_b = 1'b0;
        step();
        chk("b.empty", {31'd0, ov_b}, 32'd0);
        ordy_b = 1'b0;
        iv_b = 1'b1; id_b = 8'h81;
        #1;
        chk("b.rdy0", {31'd0, ird_b}, 32'd1);
        step();
        chk("b.ov", {31'd0, ov_b}, 32'd1);
        chk("b.od", {24'd0, od_b}, 32'h81);
        chk("b.stall.rdy", {31'd0, ird_b}, 32'd0);
        ordy_b = 1'b1;
        #1;
        chk("b.rdy.comb", {31'd0, ird_b}, 32'd1);
        ordy_b = 1'b0;
        #1;
        chk("b.rdy.comb0", {31'd0, ird_b}, 32'd0);
        id_b = 8'h82;
        step();
        chk("b.hold", {24'd0, od_b}, 32'h81);
        chk("b.hold.occ", {30'd0, occ_b}, 32'd1);
        chk("b.sc", {28'd0, sc_b}, 32'd1);
        #2;
        rstn_b = 1'b0;
        #1;
        chk("b.arst.ov", {31'd0, ov_b}, 32'd0);
        chk("b.arst.od", {24'd0, od_b}, 32'hA5);
        chk("b.arst.occ", {30'd0, occ_b}, 32'd0);
        chk("b.arst.ird", {31'd0, ird_b}, 32'd1);
        chk("b.arst.sc", {28'd0, sc_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (D/E style) of the RISC_TOY core.
- Carries an arbitrary-width packed payload between two pipeline stages using a valid/ready handshake.
- Supports synchronous flush to a configurable bubble pattern, so control fields land on their inactive values (e.g. active-low WEN/DREQ = 1).
- Optional two-entry skid buffer gives a fully registered IN_READY; also provides a saturating backpressure counter for performance monitoring.

Parameters:
- W, 32, payload width in bits (>=1).
- BUBBLE, {W{1'b0}}, payload value driven/held when no valid entry (reset, flush, drain).
- SKID_EN, 1, 1 = two-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY.
- CW, 16, width of STALL_CNT.

Ports:
- CLK, input, 1, clock, rising edge.
- RSTN, input, 1, asynchronous active-low reset.
- FLUSH, input, 1, synchronous flush; highest priority below reset.
- IN_VALID, input, 1, upstream entry valid.
- IN_READY, output, 1, stage can accept; upstream transfer (in_fire) = IN_VALID & IN_READY.
- IN_DATA, input, W, upstream payload.
- OUT_VALID, output, 1, OUT_DATA holds a valid entry.
- OUT_READY, input, 1, downstream accepts; downstream transfer (out_fire) = OUT_VALID & OUT_READY.
- OUT_DATA, output, W, registered payload; equals BUBBLE whenever OUT_VALID = 0.
- OCC, output, 2, current entry count (0..2; max 1 when SKID_EN = 0).
- CNT_CLR, input, 1, synchronous clear of STALL_CNT.
- STALL_CNT, output, CW, saturating count of cycles with OUT_VALID & ~OUT_READY.

Behaviour:
- Reset (async, RSTN = 0):
  - state EMPTY, OUT_VALID = 0, OUT_DATA = BUBBLE, skid register = BUBBLE.
  - OCC = 0, STALL_CNT = 0, IN_READY = 1.
  - Takes effect immediately, mid-transfer included; all buffered entries are lost.
- Outputs OUT_VALID, OUT_DATA and OCC come directly from flops. IN_READY is also registered when SKID_EN = 1.
- SKID_EN = 1: states EMPTY, ONE, FULL; IN_READY = (state != FULL).
  - EMPTY, in_fire: main <= IN_DATA -> ONE.
  - ONE, in_fire & out_fire: main <= IN_DATA, stay ONE.
  - ONE, in_fire & ~out_fire: skid <= IN_DATA -> FULL.
  - ONE, ~in_fire & out_fire: main <= BUBBLE -> EMPTY.
  - ONE, neither: hold.
  - FULL: no input accepted; on out_fire: main <= skid, skid <= BUBBLE -> ONE; otherwise hold.
  - Ordering is strict FIFO; no entry is duplicated or dropped.
- SKID_EN = 0: states EMPTY and ONE only; IN_READY = ~OUT_VALID | OUT_READY (combinational).
  - Transitions are as above, minus FULL.
  - Holding while OUT_READY = 0 is the stall behaviour.
- Latency: 1 cycle from in_fire to OUT_VALID when the stage is empty. Sustained throughput is 1 entry/cycle in both modes.
- FLUSH = 1 at a clock edge:
  - main and skid <= BUBBLE, state -> EMPTY, OCC -> 0, IN_READY -> 1 (registered) on the next cycle.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered to downstream.
  - FLUSH held for multiple cycles keeps the stage EMPTY.
- STALL_CNT:
  - +1 on each cycle with OUT_VALID & ~OUT_READY.
  - Saturates at 2^CW-1, no wrap.
  - CNT_CLR has priority over increment.
  - Not affected by FLUSH.
- OCC tracks the state encoding exactly: EMPTY = 0, ONE = 1, FULL = 2.
- Data path never changes while the stage holds an entry and out_fire = 0 (stall stability). Protocol checkers assert this.

Test Plan:
- Reset/idle, W=8, BUBBLE=8'hA5, SKID_EN=1: release RSTN, no input -> OUT_VALID=0, OUT_DATA=8'hA5, IN_READY=1, OCC=0 for 10 cycles.
- Streaming: IN_VALID=1 with 8'h01..8'h10 on consecutive cycles, OUT_READY=1 -> OUT_DATA 8'h01..8'h10 one cycle later, one per cycle, OCC=1 throughout, STALL_CNT=0.
- Backpressure/skid: send 8'h11, 8'h22, 8'h33, OUT_READY=0 -> OCC reaches 2, IN_READY=0 after 8'h22, 8'h33 held upstream. Raise OUT_READY -> output order 8'h11, 8'h22, 8'h33; STALL_CNT equals the stalled cycles.
- Flush with FULL and simultaneous in_fire: state FULL (8'h44, 8'h55), pulse FLUSH while IN_VALID=1/8'h66 -> next cycle OUT_VALID=0, OUT_DATA=8'hA5, OCC=0, IN_READY=1; 8'h66 never appears.
- Counter saturation: CW=4, hold OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT stops at 15. Pulse CNT_CLR while stalled -> 0, then increments again.
- SKID_EN=0 plus async reset: stall with OUT_READY=0 -> IN_READY=0 in the same cycle; assert RSTN=0 mid-stall -> outputs return to reset values immediately, before the next clock edge.
